apb_master_mc: RTL and testbench

Parametrised APB4 master that turns a valid/ready command stream into APB transfers to one of NUM_SLV slaves. It decodes the address to a one-hot psel, supports write strobes and protection, and reports decode errors and access timeouts. Responses return on a registered valid/ready channel. It sits between a protocol front-end (e.g. an AXI4-Lite slave port) and the APB peripheral fabric.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_addr_decoder.sv | 23 ++
 rtl/apb_master_mc.sv | 174 +++++++++++++++++
 tb/tb_apb_master_mc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and width helpers for the APB master and its address decoder.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  // Slave index width, never narrower than one bit.
  function automatic int idxWidth(input int numSlv);
    return (numSlv > 1) ? $clog2(numSlv) : 1;
  endfunction

  // Wait-counter width able to hold TIMEOUT; one bit when the timeout is disabled.
  function automatic int cntWidth(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a byte address to a slave index; addresses above the last region raise decErr.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int REGION_W = 12,
  parameter int NUM_SLV  = 4,
  parameter int IDX_W    = idxWidth(NUM_SLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  slvIdx,
  output logic              decErr
);

  logic [ADDR_W-1:0] region;

  always_comb begin
    region = addr >> REGION_W;
    slvIdx = region[IDX_W-1:0];
    decErr = (region >= ADDR_W'(NUM_SLV));
  end

endmodule

// File: rtl/apb_master_mc.sv
// APB4 master: valid/ready command in, one APB transfer per command, registered response out.
module apb_master_mc
  import apb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_SLV  = 4,
  parameter int REGION_W = 12,
  parameter int TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [DATA_W/8-1:0]       req_strb,
  input  logic [2:0]                req_prot,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  output logic [2:0]                pprot,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idxWidth(NUM_SLV);
  localparam int CNT_W  = cntWidth(TIMEOUT);

  apb_mst_state_t state, stateNext;

  logic              accept;
  logic              cmdPend_p0;
  logic              cmdWrite_p0;
  logic [ADDR_W-1:0] cmdAddr_p0;
  logic [DATA_W-1:0] cmdWdata_p0;
  logic [STRB_W-1:0] cmdStrb_p0;
  logic [2:0]        cmdProt_p0;
  logic [IDX_W-1:0]  cmdIdx_p0;
  logic              cmdDecErr_p0;

  logic [IDX_W-1:0]  decIdx;
  logic              decErr;
  logic [CNT_W-1:0]  waitCnt;
  logic              slvReady;
  logic              slvErr;
  logic [DATA_W-1:0] slvRdata;
  logic              toHit;

  apb_addr_decoder #(
    .ADDR_W  (ADDR_W),
    .REGION_W(REGION_W),
    .NUM_SLV (NUM_SLV),
    .IDX_W   (IDX_W)
  ) uDecoder (
    .addr  (req_addr),
    .slvIdx(decIdx),
    .decErr(decErr)
  );

  // A command sits one cycle in the pending register while its decode settles.
  assign req_ready = (state == IDLE) && !cmdPend_p0;
  assign accept    = req_ready && req_valid;

  always_comb begin
    slvReady = pready[cmdIdx_p0];
    slvErr   = pslverr[cmdIdx_p0];
    slvRdata = prdata[int'(cmdIdx_p0) * DATA_W +: DATA_W];
    toHit    = (TIMEOUT != 0) && (waitCnt == CNT_W'(TIMEOUT - 1));
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (cmdPend_p0) stateNext = cmdDecErr_p0 ? RESP : SETUP;
      SETUP:   stateNext = ACCESS;
      ACCESS:  if (slvReady || toHit) stateNext = RESP;
      RESP:    if (rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Stage p0: command capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      cmdWrite_p0  <= req_write;
      cmdAddr_p0   <= req_addr;
      cmdWdata_p0  <= req_write ? req_wdata : '0;
      cmdStrb_p0   <= req_write ? req_strb : '0;
      cmdProt_p0   <= req_prot;
      cmdIdx_p0    <= decIdx;
      cmdDecErr_p0 <= decErr;
    end
  end

  // Stage p1: APB drive and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmdPend_p0  <= 1'b0;
      waitCnt     <= '0;
      psel        <= '0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      cmdPend_p0 <= accept;
      case (state)
        IDLE: begin
          if (cmdPend_p0 && cmdDecErr_p0) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b0;
          end else if (cmdPend_p0) begin
            psel    <= NUM_SLV'(1) << cmdIdx_p0;
            penable <= 1'b0;
            pwrite  <= cmdWrite_p0;
            paddr   <= cmdAddr_p0;
            pwdata  <= cmdWdata_p0;
            pstrb   <= cmdStrb_p0;
            pprot   <= cmdProt_p0;
            waitCnt <= '0;
          end
        end
        SETUP: penable <= 1'b1;
        ACCESS: begin
          if (slvReady) begin
            psel        <= '0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= (!cmdWrite_p0 && !slvErr) ? slvRdata : '0;
            rsp_err     <= slvErr;
            rsp_timeout <= 1'b0;
          end else if (toHit) begin
            psel        <= '0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else if (waitCnt != '1) begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_mc.sv
// Directed and random transfers against a latency/response model of the APB master.
module tb_apb_master_mc;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int NUM_SLV  = 4;
  localparam int REGION_W = 12;
  localparam int TIMEOUT  = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      req_valid, req_ready, req_write;
  logic [ADDR_W-1:0]         req_addr;
  logic [DATA_W-1:0]         req_wdata;
  logic [3:0]                req_strb;
  logic [2:0]                req_prot;
  logic                      rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [NUM_SLV-1:0]        psel;
  logic                      penable, pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [3:0]                pstrb;
  logic [2:0]                pprot;
  logic [NUM_SLV*DATA_W-1:0] prdata;
  logic [NUM_SLV-1:0]        pready, pslverr;

  int          nChk = 0;
  int          nFail = 0;
  int          slvWait [NUM_SLV];
  bit          slvErrCfg [NUM_SLV];
  logic [31:0] slvData [NUM_SLV];
  logic [7:0]  accCnt = 8'd0;

  apb_master_mc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV),
    .REGION_W(REGION_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // Slave models: the selected slave answers after slvWait ACCESS cycles;
  // unselected slaves shout ready/error so a wrong index is visible.
  always @(posedge clk) begin
    if ((psel != '0) && penable) accCnt <= accCnt + 8'd1;
    else                         accCnt <= 8'd0;
  end

  always_comb begin
    pready  = '0;
    pslverr = '0;
    prdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      prdata[i*DATA_W +: DATA_W] = slvData[i];
      if (!psel[i]) begin
        pready[i]  = 1'b1;
        pslverr[i] = 1'b1;
      end else if (penable && (int'(accCnt) == slvWait[i])) begin
        pready[i]  = 1'b1;
        pslverr[i] = slvErrCfg[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one command, from region decode, slave wait states and the timeout rule.
  function automatic void model(input logic wr, input logic [31:0] addr,
                                output int lat, output int penExp, output logic eErr,
                                output logic eTo, output logic [31:0] eRd, output logic [3:0] ePsel);
    int unsigned region;
    region = addr >> REGION_W;
    eRd = 32'h0; eTo = 1'b0; eErr = 1'b0; ePsel = 4'h0;
    if (region >= NUM_SLV) begin
      lat = 1; penExp = 0; eErr = 1'b1;
    end else begin
      ePsel = 4'(1 << region);
      if (TIMEOUT != 0 && slvWait[region] >= TIMEOUT) begin
        lat = 2 + TIMEOUT; penExp = TIMEOUT; eErr = 1'b1; eTo = 1'b1;
      end else begin
        lat = 3 + slvWait[region]; penExp = slvWait[region] + 1;
        eErr = slvErrCfg[region];
        eRd = (!wr && !eErr) ? slvData[region] : 32'h0;
      end
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after the response handshake.
  task automatic doTxn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input int rspDelay);
    int lat, penExp, edgeN, penCnt, setupCnt;
    logic eErr, eTo;
    logic [31:0] eRd;
    logic [3:0] ePsel;
    bit apbOk, rdyOk, stableOk;
    model(wr, addr, lat, penExp, eErr, eTo, eRd, ePsel);
    rsp_ready = (rspDelay == 0);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wdata; req_strb = strb; req_prot = prot;
    chk("req_ready_before_cmd", 64'(req_ready), 64'(1));
    @(posedge clk);
    edgeN = 0; penCnt = 0; setupCnt = 0; apbOk = 1'b1; rdyOk = 1'b1;
    forever begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid === 1'b1 || edgeN >= 100) break;
      if (psel !== 4'h0) begin
        if (penable) penCnt++; else setupCnt++;
        if (psel !== ePsel || paddr !== addr || pwrite !== wr || pprot !== prot ||
            pwdata !== (wr ? wdata : 32'h0) || pstrb !== (wr ? strb : 4'h0)) apbOk = 1'b0;
      end else if (penable !== 1'b0) apbOk = 1'b0;
      if (req_ready !== 1'b0) rdyOk = 1'b0;
      @(posedge clk);
      edgeN++;
    end
    chk("rsp_latency", 64'(edgeN), 64'(lat));
    chk("setup_cycles", 64'(setupCnt), 64'(eErr && !eTo && penExp == 0 ? 0 : 1));
    chk("access_cycles", 64'(penCnt), 64'(penExp));
    chk("apb_signals", 64'(apbOk), 64'(1));
    chk("req_ready_busy", 64'(rdyOk), 64'(1));
    chk("rsp_err", 64'(rsp_err), 64'(eErr));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(eTo));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(eRd));
    chk("apb_idle_in_resp", 64'({psel, penable}), 64'(0));
    stableOk = 1'b1;
    for (int d = 0; d < rspDelay; d++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_err !== eErr || rsp_timeout !== eTo ||
          rsp_rdata !== eRd || req_ready !== 1'b0) stableOk = 1'b0;
    end
    if (rspDelay > 0) chk("rsp_stable_while_stalled", 64'(stableOk), 64'(1));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid_after_handshake", 64'(rsp_valid), 64'(0));
    chk("req_ready_after_handshake", 64'(req_ready), 64'(1));
  endtask

  initial begin
    logic [31:0] a;
    int s;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; rsp_ready = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      slvWait[i] = 0; slvErrCfg[i] = 1'b0; slvData[i] = 32'hA5A5_0000 + 32'(i);
    end
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'(1));
    chk("reset_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'(0));
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("reset_apb_ctrl", 64'({psel, penable, pwrite}), 64'(0));
    chk("reset_apb_data", 64'({paddr, pwdata}), 64'(0));
    chk("reset_apb_strb_prot", 64'({pstrb, pprot}), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // zero-wait write to slave 1
    doTxn(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'd2, 0);
    // read with three wait states
    slvWait[2] = 3; slvData[2] = 32'h1234_5678;
    doTxn(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'd0, 0);
    // decode error
    doTxn(1'b0, 32'h0000_5000, 32'h0, 4'h0, 3'd0, 0);
    // slave 0 never ready -> timeout
    slvWait[0] = 1000;
    doTxn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'd1, 0);
    // pready on the last allowed cycle is a normal completion
    slvWait[0] = TIMEOUT - 1;
    doTxn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'd1, 0);
    // slave error on a write, response stalled, next command back-to-back
    slvErrCfg[3] = 1'b1; slvWait[3] = 1;
    doTxn(1'b1, 32'h0000_3ffc, 32'h0BAD_F00D, 4'h5, 3'd7, 5);
    slvErrCfg[3] = 1'b0;
    doTxn(1'b1, 32'h0000_3000, 32'hCAFE_0001, 4'h3, 3'd4, 0);

    for (int n = 0; n < 40; n++) begin
      s = int'($urandom_range(0, 5));
      a = (32'(s) << REGION_W) | 32'($urandom_range(0, 4095));
      if (s == 5 && $urandom_range(0, 1) == 1) a = $urandom | 32'h8000_0000;
      if (s < NUM_SLV) begin
        slvWait[s] = int'($urandom_range(0, 4));
        slvErrCfg[s] = ($urandom_range(0, 3) == 0);
        slvData[s] = $urandom;
      end
      doTxn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end

    // asynchronous reset in the middle of ACCESS
    slvWait[0] = 1000;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (penable === 1'b1) break;
      @(negedge clk);
    end
    chk("reached_access", 64'(penable), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("async_reset_apb", 64'({psel, penable}), 64'(0));
    chk("async_reset_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_req_ready", 64'(req_ready), 64'(1));
    chk("post_reset_no_rsp", 64'(rsp_valid), 64'(0));
    slvWait[0] = 0; slvErrCfg[0] = 1'b0;
    doTxn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
